// File: rtl/core_types_pkg.sv
// Shared core type definitions: physical register tags, ROB indices,
// checkpoint columns and the physical-register allocation controller states.
package core_types_pkg;

    localparam int PHYS_REG_TAG_W   = 7;
    localparam int ROB_INDEX_W      = 6;
    localparam int CHECKPOINT_COL_W = 3;
    localparam int WALK_COUNT_W     = 16;

    typedef logic [PHYS_REG_TAG_W-1:0]   phys_reg_tag_t;
    typedef logic [ROB_INDEX_W-1:0]      ROB_index_t;
    typedef logic [CHECKPOINT_COL_W-1:0] checkpoint_column_t;

    // RUN: normal renaming; RESTORE: one-cycle checkpoint restore attempt;
    // WALK: ROB walk-back returning speculative tags to the free list.
    typedef enum logic [1:0] {
        RUN     = 2'd0,
        RESTORE = 2'd1,
        WALK    = 2'd2
    } alloc_ctrl_state_t;

endpackage

// File: rtl/phys_reg_alloc_ctrl.sv
// Physical register allocation controller. Sits beside the free list and
// arbitrates its single dequeue/enqueue ports between rename, commit-free
// and squash recovery (checkpoint restore, falling back to a ROB walk).
module phys_reg_alloc_ctrl
    import core_types_pkg::*;
(
    input  logic               CLK,
    input  logic               nRST,

    input  logic               rename_req_valid,
    output logic               rename_req_ready,
    output phys_reg_tag_t      rename_phys_reg_tag,

    input  logic               commit_free_valid,
    input  phys_reg_tag_t      commit_free_tag,
    output logic               commit_free_ready,

    input  logic               squash_valid,
    input  logic               squash_speculate_failed,
    input  ROB_index_t         squash_ROB_index,
    input  checkpoint_column_t squash_safe_column,
    output logic               squash_done,
    output logic               squash_busy,

    input  logic               walk_valid,
    input  phys_reg_tag_t      walk_tag,
    input  logic               walk_last,
    output logic               walk_ready,

    output logic               fl_dequeue_valid,
    input  phys_reg_tag_t      fl_dequeue_phys_reg_tag,
    output logic               fl_enqueue_valid,
    output phys_reg_tag_t      fl_enqueue_phys_reg_tag,
    input  logic               fl_empty,
    input  logic               fl_full,
    output logic               fl_restore_checkpoint_valid,
    output logic               fl_restore_checkpoint_speculate_failed,
    output ROB_index_t         fl_restore_checkpoint_ROB_index,
    output checkpoint_column_t fl_restore_checkpoint_safe_column,
    input  logic               fl_restore_checkpoint_success
);

    alloc_ctrl_state_t          state;
    ROB_index_t                 squash_rob_q;
    checkpoint_column_t         squash_col_q;
    logic                       squash_sf_q;
    logic [WALK_COUNT_W-1:0]    walk_count;

    // Recovery FSM: latch the squash, try the checkpoint restore, walk if it fails.
    always_ff @(posedge CLK) begin
        // NOTE: state is updated with non-blocking assignments so every register
        // samples pre-edge values regardless of statement order.
        if (!nRST) begin
            state        <= RUN;
            squash_rob_q <= '0;
            squash_col_q <= '0;
            squash_sf_q  <= 1'b0;
            squash_done  <= 1'b0;
            walk_count   <= '0;
        end else begin
            squash_done <= 1'b0;
            unique case (state)
                RUN: begin
                    if (squash_valid) begin
                        squash_rob_q <= squash_ROB_index;
                        squash_col_q <= squash_safe_column;
                        squash_sf_q  <= squash_speculate_failed;
                        state        <= RESTORE;
                    end
                end
                RESTORE: begin
                    if (fl_restore_checkpoint_success) begin
                        state       <= RUN;
                        squash_done <= 1'b1;
                    end else begin
                        state      <= WALK;
                        walk_count <= '0;
                    end
                end
                WALK: begin
                    if (walk_valid) begin
                        // Saturate so a runaway walk cannot wrap the debug count.
                        if (walk_count != '1) begin
                            walk_count <= walk_count + 1'b1;
                        end
                        if (walk_last) begin
                            state       <= RUN;
                            squash_done <= 1'b1;
                        end
                    end
                end
                default: state <= RUN;
            endcase
        end
    end

    // Handshakes and free-list port steering, all decoded from the current state.
    always_comb begin
        // NOTE: every output gets a default first so no path can infer a latch.
        rename_req_ready        = 1'b0;
        commit_free_ready       = 1'b0;
        walk_ready              = 1'b0;
        fl_enqueue_valid        = 1'b0;
        fl_enqueue_phys_reg_tag = commit_free_tag;

        // Squash takes priority over a same-cycle rename, so no dequeue then.
        if (state == RUN) begin
            rename_req_ready = ~fl_empty & ~squash_valid;
        end

        if (state == WALK) begin
            walk_ready              = 1'b1;
            fl_enqueue_valid        = walk_valid;
            fl_enqueue_phys_reg_tag = walk_tag;
        end else begin
            commit_free_ready       = ~fl_full;
            fl_enqueue_valid        = commit_free_valid & ~fl_full;
            fl_enqueue_phys_reg_tag = commit_free_tag;
        end
    end

    assign fl_dequeue_valid    = rename_req_valid & rename_req_ready;
    assign rename_phys_reg_tag = fl_dequeue_phys_reg_tag;
    assign squash_busy         = (state != RUN);

    assign fl_restore_checkpoint_valid            = (state == RESTORE);
    assign fl_restore_checkpoint_speculate_failed = squash_sf_q;
    assign fl_restore_checkpoint_ROB_index        = squash_rob_q;
    assign fl_restore_checkpoint_safe_column      = squash_col_q;

    // A squash while recovery is already in flight is dropped; flag it.
    a_squash_only_in_run: assert property (
        @(posedge CLK) disable iff (!nRST) squash_valid |-> (state == RUN)
    );

endmodule

// File: tb/tb_phys_reg_alloc_ctrl.sv
// Randomised scoreboard bench for phys_reg_alloc_ctrl. The stimulus process
// predicts each cycle's outputs from a behavioural recovery model and queues
// them; a negedge monitor pops and compares against the DUT.
module tb_phys_reg_alloc_ctrl;
    import core_types_pkg::*;

    logic               CLK = 1'b0;
    logic               nRST;
    logic               rename_req_valid;
    logic               rename_req_ready;
    phys_reg_tag_t      rename_phys_reg_tag;
    logic               commit_free_valid;
    phys_reg_tag_t      commit_free_tag;
    logic               commit_free_ready;
    logic               squash_valid;
    logic               squash_speculate_failed;
    ROB_index_t         squash_ROB_index;
    checkpoint_column_t squash_safe_column;
    logic               squash_done;
    logic               squash_busy;
    logic               walk_valid;
    phys_reg_tag_t      walk_tag;
    logic               walk_last;
    logic               walk_ready;
    logic               fl_dequeue_valid;
    phys_reg_tag_t      fl_dequeue_phys_reg_tag;
    logic               fl_enqueue_valid;
    phys_reg_tag_t      fl_enqueue_phys_reg_tag;
    logic               fl_empty;
    logic               fl_full;
    logic               fl_restore_checkpoint_valid;
    logic               fl_restore_checkpoint_speculate_failed;
    ROB_index_t         fl_restore_checkpoint_ROB_index;
    checkpoint_column_t fl_restore_checkpoint_safe_column;
    logic               fl_restore_checkpoint_success;

    phys_reg_alloc_ctrl dut (
        .CLK                                   (CLK),
        .nRST                                  (nRST),
        .rename_req_valid                      (rename_req_valid),
        .rename_req_ready                      (rename_req_ready),
        .rename_phys_reg_tag                   (rename_phys_reg_tag),
        .commit_free_valid                     (commit_free_valid),
        .commit_free_tag                       (commit_free_tag),
        .commit_free_ready                     (commit_free_ready),
        .squash_valid                          (squash_valid),
        .squash_speculate_failed               (squash_speculate_failed),
        .squash_ROB_index                      (squash_ROB_index),
        .squash_safe_column                    (squash_safe_column),
        .squash_done                           (squash_done),
        .squash_busy                           (squash_busy),
        .walk_valid                            (walk_valid),
        .walk_tag                              (walk_tag),
        .walk_last                             (walk_last),
        .walk_ready                            (walk_ready),
        .fl_dequeue_valid                      (fl_dequeue_valid),
        .fl_dequeue_phys_reg_tag               (fl_dequeue_phys_reg_tag),
        .fl_enqueue_valid                      (fl_enqueue_valid),
        .fl_enqueue_phys_reg_tag               (fl_enqueue_phys_reg_tag),
        .fl_empty                              (fl_empty),
        .fl_full                               (fl_full),
        .fl_restore_checkpoint_valid           (fl_restore_checkpoint_valid),
        .fl_restore_checkpoint_speculate_failed(fl_restore_checkpoint_speculate_failed),
        .fl_restore_checkpoint_ROB_index       (fl_restore_checkpoint_ROB_index),
        .fl_restore_checkpoint_safe_column     (fl_restore_checkpoint_safe_column),
        .fl_restore_checkpoint_success         (fl_restore_checkpoint_success)
    );

    always #5 CLK = ~CLK;

    // Expected observation for one clock cycle.
    typedef struct {
        int          cyc;
        logic        rr;
        logic        deq;
        logic [6:0]  deq_tag;
        logic        cfr;
        logic        wr;
        logic        busy;
        logic        done;
        logic        enq;
        logic [6:0]  enq_tag;
        logic        rst_v;
        logic [5:0]  rob;
        logic [2:0]  col;
        logic        sf;
        logic [15:0] wc;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;

    // Behavioural model: where the squash recovery stands, in plain terms.
    bit          m_valid      = 0;  // model known (after first reset edge)
    bit          m_restoring  = 0;  // checkpoint restore attempt this cycle
    bit          m_walking    = 0;  // walk-back in progress
    bit          m_done       = 0;  // recovery finished last cycle
    logic [5:0]  m_rob        = '0;
    logic [2:0]  m_col        = '0;
    bit          m_sf         = 0;
    int          m_walk_n     = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s cycle=%0d actual=%0h required=%0h", name, cyc, act, req);
        end
    endtask

    // Monitor: compare whatever the DUT presents this cycle with the queued prediction.
    initial begin
        exp_t e;
        forever begin
            @(negedge CLK);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("rename_req_ready",  32'(rename_req_ready),  32'(e.rr));
                check("fl_dequeue_valid",  32'(fl_dequeue_valid),  32'(e.deq));
                if (e.deq) check("rename_tag", 32'(rename_phys_reg_tag), 32'(e.deq_tag));
                check("commit_free_ready", 32'(commit_free_ready), 32'(e.cfr));
                check("walk_ready",        32'(walk_ready),        32'(e.wr));
                check("squash_busy",       32'(squash_busy),       32'(e.busy));
                check("squash_done",       32'(squash_done),       32'(e.done));
                check("fl_enqueue_valid",  32'(fl_enqueue_valid),  32'(e.enq));
                if (e.enq) check("fl_enqueue_tag", 32'(fl_enqueue_phys_reg_tag), 32'(e.enq_tag));
                check("restore_valid",     32'(fl_restore_checkpoint_valid), 32'(e.rst_v));
                if (e.rst_v) begin
                    check("restore_rob", 32'(fl_restore_checkpoint_ROB_index),        32'(e.rob));
                    check("restore_col", 32'(fl_restore_checkpoint_safe_column),      32'(e.col));
                    check("restore_sf",  32'(fl_restore_checkpoint_speculate_failed), 32'(e.sf));
                end
                check("walk_count", 32'(dut.walk_count), 32'(e.wc));
            end
        end
    end

    // Predict this cycle's outputs from current inputs, advance the model, clock once.
    task automatic step();
        exp_t e;
        bit   idle;
        idle = !m_restoring && !m_walking;
        if (m_valid) begin
            e.cyc     = cyc;
            e.rr      = idle && !fl_empty && !squash_valid;
            e.deq     = e.rr && rename_req_valid;
            e.deq_tag = fl_dequeue_phys_reg_tag;
            e.cfr     = !m_walking && !fl_full;
            e.wr      = m_walking;
            e.busy    = !idle;
            e.done    = m_done;
            e.enq     = m_walking ? walk_valid : (commit_free_valid && !fl_full);
            e.enq_tag = m_walking ? walk_tag : commit_free_tag;
            e.rst_v   = m_restoring;
            e.rob     = m_rob;
            e.col     = m_col;
            e.sf      = m_sf;
            e.wc      = 16'(m_walk_n);
            exp_q.push_back(e);
        end
        if (!nRST) begin
            m_valid = 1; m_restoring = 0; m_walking = 0; m_done = 0;
            m_rob = '0; m_col = '0; m_sf = 0; m_walk_n = 0;
        end else if (m_valid) begin
            m_done = 0;
            if (idle && squash_valid) begin
                m_restoring = 1;
                m_rob = squash_ROB_index; m_col = squash_safe_column; m_sf = squash_speculate_failed;
            end else if (m_restoring) begin
                m_restoring = 0;
                if (fl_restore_checkpoint_success) m_done = 1;
                else begin m_walking = 1; m_walk_n = 0; end
            end else if (m_walking && walk_valid) begin
                if (m_walk_n < 65535) m_walk_n++;
                if (walk_last) begin m_walking = 0; m_done = 1; end
            end
        end
        @(posedge CLK);
        #1;
        cyc++;
    endtask

    task automatic idle_inputs();
        rename_req_valid = 0; commit_free_valid = 0; commit_free_tag = '0;
        squash_valid = 0; squash_speculate_failed = 0; squash_ROB_index = '0; squash_safe_column = '0;
        walk_valid = 0; walk_tag = '0; walk_last = 0;
        fl_empty = 0; fl_full = 0; fl_dequeue_phys_reg_tag = '0; fl_restore_checkpoint_success = 0;
    endtask

    task automatic squash(input logic [5:0] rob, input logic [2:0] col, input bit success);
        idle_inputs();
        squash_valid = 1; squash_ROB_index = rob; squash_safe_column = col;
        squash_speculate_failed = 1; rename_req_valid = 1;
        step();
        idle_inputs();
        fl_restore_checkpoint_success = success;
        step();
        idle_inputs();
    endtask

    initial begin
        idle_inputs();
        nRST = 0;
        step();
        step();
        nRST = 1;

        // Rename with a non-empty free list: zero-latency grant of tag 0x20.
        fl_dequeue_phys_reg_tag = 7'h20; rename_req_valid = 1;
        step();
        // Empty free list blocks the grant.
        fl_empty = 1;
        step();
        idle_inputs();

        // Squash with successful restore: ROB 5, column 2.
        squash(6'd5, 3'd2, 1);
        step();
        step();

        // Squash with failed restore, then walk 0x21, 0x22 (last); commit is held off.
        squash(6'd9, 3'd4, 0);
        walk_valid = 1; walk_tag = 7'h21; commit_free_valid = 1; commit_free_tag = 7'h11;
        step();
        walk_tag = 7'h22; walk_last = 1;
        step();
        idle_inputs();
        step();

        // Commit free and rename together; then a full free list blocks commit.
        commit_free_valid = 1; commit_free_tag = 7'h07;
        rename_req_valid = 1; fl_dequeue_phys_reg_tag = 7'h33;
        step();
        fl_full = 1;
        step();
        idle_inputs();

        // Reset in the middle of a walk: back to RUN, no done pulse.
        squash(6'd3, 3'd1, 0);
        walk_valid = 1; walk_tag = 7'h2a;
        step();
        idle_inputs();
        nRST = 0;
        step();
        nRST = 1;
        step();
        step();

        // Randomised traffic.
        for (int i = 0; i < 600; i++) begin
            bit idle;
            idle = !m_restoring && !m_walking;
            nRST                          = ($urandom_range(0, 63) != 0);
            rename_req_valid              = $urandom_range(0, 1);
            fl_dequeue_phys_reg_tag       = 7'($urandom);
            fl_empty                      = ($urandom_range(0, 3) == 0);
            fl_full                       = ($urandom_range(0, 3) == 0);
            commit_free_valid             = $urandom_range(0, 1);
            commit_free_tag               = 7'($urandom);
            squash_valid                  = idle && nRST && ($urandom_range(0, 7) == 0);
            squash_speculate_failed       = $urandom_range(0, 1);
            squash_ROB_index              = 6'($urandom);
            squash_safe_column            = 3'($urandom);
            walk_valid                    = $urandom_range(0, 1);
            walk_tag                      = 7'($urandom);
            walk_last                     = ($urandom_range(0, 3) == 0);
            fl_restore_checkpoint_success = $urandom_range(0, 1);
            step();
        end
        nRST = 1;
        idle_inputs();
        step();

        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge CLK);
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/phys_reg_alloc_ctrl.md
PHYS_REG_ALLOC_CTRL -- requirements
Module: phys_reg_alloc_ctrl

Interface
REQ-001 SHALL have ports: CLK  in  1  clock; nRST  in  1  reset, synchronous, active-low.
REQ-002 SHALL have: rename_req_valid  in  1  rename requests one phys reg.
REQ-003 SHALL have: rename_req_ready  out  1  grant; allocation occurs when valid&ready.
REQ-004 SHALL have: rename_phys_reg_tag  out  phys_reg_tag_t  allocated tag, same cycle as grant.
REQ-005 SHALL have: commit_free_valid  in  1, commit_free_tag  in  phys_reg_tag_t, commit_free_ready  out  1  retire-freed old tag.
REQ-006 SHALL have: squash_valid  in  1, squash_speculate_failed  in  1, squash_ROB_index  in  ROB_index_t, squash_safe_column  in  checkpoint_column_t  squash request.
REQ-007 SHALL have: squash_done  out  1  one-cycle pulse at squash completion; squash_busy  out  1  high while not RUN.
REQ-008 SHALL have: walk_valid  in  1, walk_tag  in  phys_reg_tag_t, walk_last  in  1, walk_ready  out  1  ROB walk-back of speculative tags.
REQ-009 SHALL have free-list master ports: fl_dequeue_valid out 1; fl_dequeue_phys_reg_tag in; fl_enqueue_valid out 1; fl_enqueue_phys_reg_tag out; fl_empty in 1; fl_full in 1; fl_restore_checkpoint_valid out 1; fl_restore_checkpoint_speculate_failed out 1; fl_restore_checkpoint_ROB_index out; fl_restore_checkpoint_safe_column out; fl_restore_checkpoint_success in 1 (same-cycle response).

Function
REQ-010 SHALL implement FSM states RUN, RESTORE, WALK; reset state RUN.
REQ-011 RUN: rename_req_ready = ~fl_empty & ~squash_valid; fl_dequeue_valid = rename_req_valid & rename_req_ready; rename_phys_reg_tag = fl_dequeue_phys_reg_tag (combinational, 0-cycle latency).
REQ-012 RUN + squash_valid: latch ROB index, safe column, speculate_failed; next state RESTORE; squash wins over same-cycle rename (no dequeue).
REQ-013 RESTORE (exactly 1 cycle): drive fl_restore_checkpoint_valid=1 with latched fields; success -> RUN with squash_done=1 next cycle; failure -> WALK.
REQ-014 WALK: walk_ready=1; each walk_valid enqueues walk_tag; walk_valid&walk_last -> RUN, squash_done=1 next cycle.
REQ-015 rename_req_ready SHALL be 0 in RESTORE and WALK.
REQ-016 Enqueue arbitration: single fl enqueue port; WALK: walk source only, commit_free_ready=0; RUN/RESTORE: commit source, commit_free_ready = ~fl_full.
REQ-017 fl_enqueue_valid = selected source valid & its ready; fl_enqueue_phys_reg_tag = selected source tag.
REQ-018 Simultaneous commit free and rename in RUN SHALL both proceed same cycle.
REQ-019 squash_valid outside RUN SHALL be ignored; flag via assertion.
REQ-020 walk_valid outside WALK SHALL be ignored (no enqueue).
REQ-021 squash_busy = (state != RUN); squash_done registered, high exactly one cycle.
REQ-022 SHALL keep 16-bit saturating counter walk_count of tags enqueued in current WALK, cleared on WALK entry (debug/assertion only).

Reset
REQ-023 Reset (nRST=0 at CLK edge) SHALL force state RUN, latched squash fields 0, squash_done 0, walk_count 0.
REQ-024 During/after reset all fl_*_valid outputs SHALL be 0 unless driven by RUN handshake; reset mid-WALK abandons walk with no squash_done.

Structure
REQ-025 phys_reg_tag_t, ROB_index_t, checkpoint_column_t SHALL come from core_types_pkg; FSM enum alloc_ctrl_state_t SHALL be added there.
REQ-026 SHALL be flat, no sub-module; instantiated beside phys_reg_free_list in core.

Verification
REQ-027 Reset, fl_empty=0, fl tag 0x20, rename_req_valid=1 -> ready=1, fl_dequeue_valid=1, rename_phys_reg_tag=0x20 same cycle.
REQ-028 fl_empty=1, rename_req_valid=1 -> ready=0, fl_dequeue_valid=0.
REQ-029 squash (ROB 5, col 2) with fl success=1 -> next cycle restore_valid=1, ROB 5, col 2; following cycle squash_done=1, state RUN.
REQ-030 squash with success=0, walk tags 0x21,0x22 (last) -> two enqueues of 0x21,0x22, commit_free_ready=0 throughout WALK, squash_done after last, walk_count=2.
REQ-031 Commit free 0x07 and rename same cycle in RUN -> fl_enqueue_valid=1 tag 0x07 and fl_dequeue_valid=1; fl_full=1 -> commit_free_ready=0.
REQ-032 nRST=0 mid-WALK -> state RUN, squash_busy=0, no squash_done pulse.
